// File: rtl/counter_pkg.sv
// counter_pkg: constants and helpers shared by mod_counter and tick_gen.
//   DefWidth / DefModulus / DefDiv : default parameter values for mod_counter
//   BoardClkHz                     : board oscillator frequency
//   pre_width()                    : bit width needed for a 0..div-1 prescaler counter
package counter_pkg;

    localparam int unsigned     BoardClkHz = 50_000_000;
    localparam int unsigned     DefWidth   = 4;
    localparam longint unsigned DefModulus = 16;
    // One count per second at the board clock.
    localparam int unsigned     DefDiv     = BoardClkHz;

    // Width of a counter holding 0..div-1; never less than one bit.
    function automatic int unsigned pre_width(input int unsigned div);
        if (div <= 1) begin
            return 1;
        end
        return $clog2(div);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: clock-enable prescaler producing a one-cycle strobe every DIV enabled cycles.
// Ports:
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   en    in  advance enable; en=0 freezes the prescaler and forces tick=0
//   clear in  synchronous restart of the prescaler from 0
//   tick  out strobe, combinational from the prescaler state and en
module tick_gen
    import counter_pkg::*;
#(
    parameter int unsigned DIV = DefDiv
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     PreW = pre_width(DIV);
    localparam logic [PreW-1:0] Last = PreW'(DIV - 1);

    logic [PreW-1:0] pre_q;
    logic [PreW-1:0] pre_d;

    assign tick = en & (pre_q == Last);

    always_comb begin
        pre_d = pre_q;
        if (clear) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + PreW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: modulo-MODULUS up/down counter advanced by a clock-enable prescaler strobe.
// Build option: define MOD_COUNTER_PRESCALE_EN to instantiate the DIV prescaler (tick_gen);
// otherwise tick = en and the counter steps on every enabled cycle.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   en       in  count enable, gates prescaler and counter
//   up       in  1 = count up, 0 = count down
//   clear    in  synchronous clear of counter, prescaler and tc
//   load     in  synchronous load of load_val (clamped to MODULUS-1)
//   load_val in  load value
//   count    out current count (registered)
//   tc       out one-cycle pulse after a wrapping step (registered)
//   tick     out prescaler strobe
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = DefWidth,
    parameter longint unsigned MODULUS = DefModulus,
    parameter int unsigned     DIV     = DefDiv
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             tick
);

    // Compare against MODULUS-1 in WIDTH bits so MODULUS = 2^WIDTH needs no extra bit.
    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

    logic             tick_int;
    logic             step;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

`ifdef MOD_COUNTER_PRESCALE_EN
    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clear (clear),
        .tick  (tick_int)
    );
`else
    // No prescaler: every enabled cycle is a step. An illegal DIV=0 stalls the counter.
    if (DIV >= 1) begin : g_no_prescale
        assign tick_int = en;
    end else begin : g_div_invalid
        assign tick_int = 1'b0;
    end
`endif

    assign step  = en & tick_int;
    assign tick  = tick_int;
    assign count = count_q;
    assign tc    = tc_q;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (step) begin
            if (up) begin
                if (count_q == MaxVal) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MaxVal;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo-N up/down counter with a built-in clock-enable prescaler. It is the successor to the fixed 4-bit free-running counter and its divided-clock scheme. Everything runs on the single system clock; the slow count rate comes from a one-cycle enable strobe, never from a derived clock. Intended for display scanning, timers and board-level demo counters driven from the FPGA oscillator.

## Interface
- WIDTH, 4: count register width in bits; legal range 1..32.
- MODULUS, 16: count wraps modulo MODULUS; legal range 2..2^WIDTH.
- DIV, 50_000_000: prescaler period in clk cycles; legal range ≥1.

- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  count enable; gates both the prescaler and the counter.
- up  in  1  direction: 1 counts up, 0 counts down; sampled at each step.
- clear  in  1  synchronous clear of counter, prescaler and tc.
- load  in  1  synchronous parallel load of the counter.
- load_val  in  WIDTH  load value.
- count  out  WIDTH  current count, registered.
- tc  out  1  terminal-count pulse, registered, one cycle per wrap.
- tick  out  1  prescaler strobe; the counter advances when tick=1 and en=1.

## Operation
- Update priority per edge: rst > clear > load > step > hold.
- step = en & tick.
- Up step: count==MODULUS-1 → 0, otherwise count+1.
- Down step: count==0 → MODULUS-1, otherwise count-1.
- Direction changes take effect at the next step with no extra delay.
- Load: count ← load_val. Values ≥ MODULUS are clamped to MODULUS-1. Load does not touch the prescaler. tc=0 in the following cycle.
- Clear: count ← 0, prescaler ← 0, tc ← 0.
- tc goes to 1 for exactly the cycle after a step that wrapped (in either direction). Otherwise tc is 0.
- Prescaler:
  - Internal counter pre counts 0..DIV-1, advancing only while en=1.
  - tick = en & (pre==DIV-1); combinational from pre and en.
  - pre wraps to 0 on the cycle tick is high.
  - en=0 freezes pre, and therefore tick=0.
- DIV=1: tick = en, so the counter steps on every enabled cycle.
- Arithmetic is done in WIDTH bits. MODULUS = 2^WIDTH must give natural wrap with no overflow on the MODULUS-1 compare.

## Timing
- Reset values: count=0, tc=0, tick=0, pre=0.
- Reset acts immediately on assertion. First possible step is on the first edge after deassertion.
- count changes on the edge where step=1; latency is 1 cycle from the tick cycle to the new count.
- Load and clear likewise land at the next edge.
- Simultaneous clear+load: clear wins. Simultaneous load+step: load wins, and the step is lost.
- In steady state with en held high, count advances once every DIV cycles.
- rst asserted mid-period: pre restarts from 0, so the first post-reset step comes exactly DIV enabled cycles after reset release.

## Configuration
- MOD_COUNTER_PRESCALE_EN defined:
  - The prescaler is instantiated and DIV is honoured.
- MOD_COUNTER_PRESCALE_EN undefined:
  - No prescaler logic; DIV is ignored.
  - tick = en, and the counter steps on every enabled cycle, the same as DIV=1.
  - All other behaviour is unchanged.

## Structure
- Shared package counter_pkg holds:
  - the default WIDTH, MODULUS and DIV constants;
  - the board clock frequency constant;
  - a clog2-based width helper for sizing pre.
- Sub-module tick_gen holds the prescaler.
  - Ports: clk, rst, en, clear → tick.
  - Parameter: DIV.
  - Instantiated only under MOD_COUNTER_PRESCALE_EN.
- Counter and tc logic live in mod_counter itself.

## Test plan
All scenarios use WIDTH=4, MODULUS=10, DIV=4 unless noted.
- Reset: assert rst mid-count → count=0, tc=0, tick=0 immediately; after release with en=1, first step at cycle 4.
- Up wrap: en=1, up=1 from 0 → count visits 0..9 then 0, once every 4 cycles; tc high for the single cycle after 9→0.
- Down wrap: up=0 at count=0 → next step gives 9 and tc pulses; flipping up at count=5 gives 6 on the next step.
- Load and clamp: load=1, load_val=7 → count=7 next cycle. load_val=12 → count=9. load together with a step → count=load value and tc=0.
- Clear priority: clear=1 and load=1 together with pre=2 → count=0, pre=0; next step occurs 4 enabled cycles later.
- Enable gating: drop en for 10 cycles mid-period → count and pre frozen, tick=0; counting resumes with the remaining prescaler cycles. Rerun with the macro undefined → a step on every enabled cycle.
